// File: rtl/avalon_burst_write_arbiter.sv
// Purpose : shares one Avalon-MM burst write master between two burst-write requesters,
//           granting whole bursts round-robin and never interleaving them.
// Latency : a command seen in IDLE drives master_write on the next cycle. Data ack is
//           combinational from the Avalon handshake.
// Backpressure: master_waitrequest stalls the current beat. Writedata and ack hold until it drops.
//
// Ports   : clk/reset (synchronous, active-high)
//           reqN_valid/address/burstcount -> reqN_ready (1-cycle command accept pulse)
//           reqN_writedata -> reqN_data_ack (word consumed this cycle)
//           grant/busy status; master_* Avalon-MM burst write port
// Option  : `define ARB_FIXED_PRIORITY_EN makes requester 0 win every tie.
//           The default is round-robin.
module avalon_burst_write_arbiter #(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int BYTE_ENABLE_WIDTH = 4,
    parameter int BURST_WIDTH       = 4
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         req0_valid,
    input  logic [ADDRESS_WIDTH-1:0]     req0_address,
    input  logic [BURST_WIDTH-1:0]       req0_burstcount,
    output logic                         req0_ready,
    input  logic [DATA_WIDTH-1:0]        req0_writedata,
    output logic                         req0_data_ack,

    input  logic                         req1_valid,
    input  logic [ADDRESS_WIDTH-1:0]     req1_address,
    input  logic [BURST_WIDTH-1:0]       req1_burstcount,
    output logic                         req1_ready,
    input  logic [DATA_WIDTH-1:0]        req1_writedata,
    output logic                         req1_data_ack,

    output logic                         grant,
    output logic                         busy,

    output logic [ADDRESS_WIDTH-1:0]     master_address,
    output logic                         master_write,
    output logic [DATA_WIDTH-1:0]        master_writedata,
    output logic [BURST_WIDTH-1:0]       master_burstcount,
    output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
    input  logic                         master_waitrequest
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]             state;
    logic                   last_grant;
    logic [BURST_WIDTH-1:0] beat_cnt;

    logic                     sel_vld;
    logic                     sel_idx;
    logic [ADDRESS_WIDTH-1:0] sel_address;
    logic [BURST_WIDTH-1:0]   sel_burstcount;
    logic                     beat_accepted;

    // Selection is held off while a ready pulse is out. A requester only sees its
    // ready one cycle after acceptance. Without the hold-off, a zero-length command
    // (which leaves us in IDLE) would be accepted twice.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = 1'b0;
        if (state == ST_IDLE && !req0_ready && !req1_ready) begin
            if (req0_valid && req1_valid) begin
                sel_vld = 1'b1;
`ifdef ARB_FIXED_PRIORITY_EN
                sel_idx = 1'b0;
`else
                sel_idx = ~last_grant;
`endif
            end else if (req0_valid) begin
                sel_vld = 1'b1;
                sel_idx = 1'b0;
            end else if (req1_valid) begin
                sel_vld = 1'b1;
                sel_idx = 1'b1;
            end
        end
    end

    assign sel_address    = sel_idx ? req1_address    : req0_address;
    assign sel_burstcount = sel_idx ? req1_burstcount : req0_burstcount;

    assign beat_accepted     = master_write & ~master_waitrequest;
    assign master_writedata  = grant ? req1_writedata : req0_writedata;
    assign master_byteenable = '1;

    // A reset cycle aborts the burst. No word is reported consumed on it.
    assign req0_data_ack = beat_accepted & ~reset & ~grant;
    assign req1_data_ack = beat_accepted & ~reset &  grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            last_grant        <= 1'b1;
            grant             <= 1'b0;
            busy              <= 1'b0;
            req0_ready        <= 1'b0;
            req1_ready        <= 1'b0;
            master_write      <= 1'b0;
            master_address    <= '0;
            master_burstcount <= '0;
            beat_cnt          <= '0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_vld) begin
                        req0_ready        <= ~sel_idx;
                        req1_ready        <=  sel_idx;
                        grant             <= sel_idx;
                        last_grant        <= sel_idx;
                        master_address    <= sel_address;
                        master_burstcount <= sel_burstcount;
                        beat_cnt          <= sel_burstcount;
                        // A zero-length command is consumed but produces no transaction.
                        if (sel_burstcount != '0) begin
                            master_write <= 1'b1;
                            busy         <= 1'b1;
                            state        <= ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    if (beat_accepted) begin
                        if (beat_cnt == BURST_WIDTH'(1)) begin
                            master_write <= 1'b0;
                            busy         <= 1'b0;
                            beat_cnt     <= '0;
                            state        <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    master_write <= 1'b0;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
